// File: rtl/ram_pkg.sv
// Shared types for the self-initialising RAM: read-during-write policy and controller states.
package ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port storage with per-lane write enables and a registered read port.
// Latency 1 on reads; no backpressure, every strobe is taken on the edge it is presented.
module ram_array
    import ram_pkg::*;
#(
    parameter int        ADDR_W   = 10,
    parameter int        LANE_W   = 8,
    parameter int        LANES    = 1,
    parameter rdw_mode_e RDW_MODE = READ_FIRST
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      re,
    input  logic [LANES-1:0]          we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [LANE_W*LANES-1:0]   wdata,
    output logic [LANE_W*LANES-1:0]   rdata
);

    localparam int DATA_W = LANE_W * LANES;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] rdata_q;

    assign old_word = mem_q[addr];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                merged_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Storage carries no reset; its contents are defined only by the clear sweep.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem_q[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= (RDW_MODE == WRITE_FIRST) ? merged_word : old_word;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_init.sv
// RAM wrapper that sweeps INIT_VAL through every word after reset or clr, then serves user accesses.
// Read latency 1; ready is low for the 2**ADDR_W sweep cycles and accesses presented then are dropped.
module ram_init
    import ram_pkg::*;
#(
    parameter int                       ADDR_W   = 10,
    parameter int                       LANE_W   = 8,
    parameter int                       LANES    = 1,
    parameter rdw_mode_e                RDW_MODE = READ_FIRST,
    parameter logic [LANE_W*LANES-1:0]  INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      rd,
    input  logic                      wr,
    input  logic [LANES-1:0]          be,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [LANE_W*LANES-1:0]   din,
    input  logic                      clr,
    output logic [LANE_W*LANES-1:0]   dout,
    output logic                      rvalid,
    output logic                      ready
);

    localparam int DATA_W = LANE_W * LANES;

    ram_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               rvalid_q, rvalid_d;

    logic               arr_re;
    logic [LANES-1:0]   arr_we;
    logic [ADDR_W-1:0]  arr_addr;
    logic [DATA_W-1:0]  arr_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rvalid_d  = 1'b0;
        arr_re    = 1'b0;
        arr_we    = '0;
        arr_addr  = addr;
        arr_wdata = din;

        unique case (state_q)
            CLEAR: begin
                arr_we    = '1;
                arr_addr  = cnt_q;
                arr_wdata = INIT_VAL;
                if (clr) begin
                    cnt_d = '0;
                end else begin
                    // The counter wraps to zero on the same edge it writes the last word.
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (ena) begin
                    arr_re   = rd;
                    rvalid_d = rd;
                    arr_we   = wr ? be : '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    ram_array #(
        .ADDR_W   (ADDR_W),
        .LANE_W   (LANE_W),
        .LANES    (LANES),
        .RDW_MODE (RDW_MODE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (arr_re),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (dout)
    );

    assign rvalid = rvalid_q;
    assign ready  = (state_q == READY);

endmodule

// File: tb/tb_ram_init.sv
// Two instances (read-first and write-first) driven in lockstep and checked against a word-level model.
module tb_ram_init;
    import ram_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [15:0] INIT0 = 16'h0000;
    localparam logic [15:0] INIT1 = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0, rd = 1'b0, wr = 1'b0, clr = 1'b0;
    logic [1:0]  be = '0;
    logic [3:0]  addr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout0, dout1;
    logic        rvalid0, rvalid1, ready0, ready1;

    int checks = 0;
    int passed = 0;
    bit go = 1'b0;

    always #5 clk = ~clk;

    ram_init #(.ADDR_W(AW), .LANE_W(8), .LANES(2), .RDW_MODE(READ_FIRST), .INIT_VAL(INIT0)) dut_rf (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rd(rd), .wr(wr), .be(be), .addr(addr),
        .din(din), .clr(clr), .dout(dout0), .rvalid(rvalid0), .ready(ready0));

    ram_init #(.ADDR_W(AW), .LANE_W(8), .LANES(2), .RDW_MODE(WRITE_FIRST), .INIT_VAL(INIT1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rd(rd), .wr(wr), .be(be), .addr(addr),
        .din(din), .clr(clr), .dout(dout1), .rvalid(rvalid1), .ready(ready1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Word-level model: a sweep is just "memory becomes INIT, then DEPTH busy cycles".
    logic [15:0] m_mem [2][DEPTH];
    logic [15:0] m_dout [2];
    logic        m_rvalid;
    int          m_busy;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] b);
        return {b[1] ? nw[15:8] : old[15:8], b[0] ? nw[7:0] : old[7:0]};
    endfunction

    task automatic m_fill();
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[0][a] = INIT0;
            m_mem[1][a] = INIT1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = DEPTH;
            m_rvalid = 1'b0;
            m_dout[0] = '0;
            m_dout[1] = '0;
            m_fill();
        end else if (m_busy > 0) begin
            m_rvalid = 1'b0;
            m_busy   = clr ? DEPTH : m_busy - 1;
        end else if (clr) begin
            m_rvalid = 1'b0;
            m_busy   = DEPTH;
            m_fill();
        end else begin
            m_rvalid = ena && rd;
            for (int k = 0; k < 2; k++) begin
                logic [15:0] old, mrg;
                old = m_mem[k][addr];
                mrg = wr ? merge(old, din, be) : old;
                if (ena && rd) m_dout[k] = (k == 1) ? mrg : old;
                if (ena && wr) m_mem[k][addr] = mrg;
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("ready_rf",  ready0,  m_busy == 0);
            chk("ready_wf",  ready1,  m_busy == 0);
            chk("rvalid_rf", rvalid0, m_rvalid);
            chk("rvalid_wf", rvalid1, m_rvalid);
            chk("dout_rf",   dout0,   m_dout[0]);
            chk("dout_wf",   dout1,   m_dout[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 0; rd = 0; wr = 0; clr = 0; be = '0;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!ready0 && n < 64) begin
            n++;
            step();
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [3:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        ena = 1; rd = r; wr = w; addr = a; din = d; be = b; clr = 0;
        step();
        idle();
    endtask

    initial begin
        int n;
        idle();
        rst_n = 0;
        #1 go = 1'b1;
        step(); step();
        chk("rst_ready", ready0, 1'b0);
        chk("rst_rvalid", rvalid0, 1'b0);
        chk("rst_dout", dout1, 16'h0000);
        rst_n = 1;
        count_low(n);
        chk("reset_sweep_len", n, 16);

        for (int a = 0; a < DEPTH; a++) begin
            access(1, 0, 4'(a), 16'h0, 2'b00);
            chk("init_rf", dout0, INIT0);
            chk("init_wf", dout1, INIT1);
        end

        access(0, 1, 4'd3, 16'hABCD, 2'b01);
        access(1, 0, 4'd3, 16'h0, 2'b00);
        chk("lane_rvalid", rvalid0, 1'b1);
        chk("lane_rf", dout0, 16'h00CD);
        chk("lane_wf", dout1, 16'h5ACD);
        step();
        chk("lane_rvalid_drop", rvalid0, 1'b0);

        access(0, 1, 4'd5, 16'h0011, 2'b11);
        access(1, 1, 4'd5, 16'h0022, 2'b11);
        chk("rdw_rf", dout0, 16'h0011);
        chk("rdw_wf", dout1, 16'h0022);
        access(1, 0, 4'd5, 16'h0, 2'b00);
        chk("rdw_after_rf", dout0, 16'h0022);
        chk("rdw_after_wf", dout1, 16'h0022);

        access(0, 1, 4'd7, 16'h1234, 2'b00);
        access(1, 0, 4'd7, 16'h0, 2'b00);
        chk("be0_rf", dout0, INIT0);

        access(1, 0, 4'd5, 16'h0, 2'b00);
        ena = 1; wr = 1; addr = 4'd0; din = 16'h0055; be = 2'b11; clr = 1;
        step();
        idle();
        ena = 1; rd = 1; addr = 4'd5;
        count_low(n);
        idle();
        chk("clr_sweep_len", n, 16);
        chk("clr_dout_hold", dout0, 16'h0022);
        access(1, 0, 4'd0, 16'h0, 2'b00);
        chk("clr_drop_rf", dout0, INIT0);
        chk("clr_drop_wf", dout1, INIT1);

        clr = 1; step(); clr = 0;
        repeat (8) step();
        clr = 1; step(); clr = 0;
        count_low(n);
        chk("clr_restart_len", n, 16);

        clr = 1; step(); clr = 0;
        repeat (6) step();
        rst_n = 0; step(); rst_n = 1;
        count_low(n);
        chk("rst_restart_len", n, 16);

        for (int c = 0; c < 3000; c++) begin
            ena  = ($urandom % 4) != 0;
            rd   = $urandom % 2;
            wr   = $urandom % 2;
            be   = 2'($urandom);
            addr = 4'($urandom);
            din  = 16'($urandom);
            clr  = ($urandom % 150) == 0;
            if (($urandom % 700) == 0) begin
                rst_n = 0; step(); rst_n = 1;
            end else begin
                step();
            end
        end
        idle();
        step(); step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
